// File: rtl/fir_tap_ram_arbiter.sv
// fir_tap_ram_arbiter
// Shares the single-port 11-entry tap BRAM (1-cycle registered read) between
// the AXI-lite configuration path (read/write) and the FIR engine (read-only).
// Coefficient writes are held off while a frame is in flight. A config read
// that keeps losing to the engine is forced through after pMAX_WAIT losses.
// Optional feature: define FIR_TAP_ARB_STATS_EN to add cfg_stall_cnt, a
// saturating count of cycles in which a config request waited.
module fir_tap_ram_arbiter #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pMAX_WAIT   = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   cfg_req,
    input  logic                   cfg_we,
    input  logic [pADDR_WIDTH-1:0] cfg_addr,
    input  logic [pDATA_WIDTH-1:0] cfg_wdata,
    output logic                   cfg_gnt,
    output logic                   cfg_rvalid,
    output logic [pDATA_WIDTH-1:0] cfg_rdata,
    input  logic                   eng_req,
    input  logic [pADDR_WIDTH-1:0] eng_addr,
    output logic                   eng_gnt,
    output logic                   eng_rvalid,
    output logic [pDATA_WIDTH-1:0] eng_rdata,
    input  logic                   eng_busy,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do
`ifdef FIR_TAP_ARB_STATS_EN
    ,
    output logic [15:0]            cfg_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CFG  = 2'd1,
        TAG_ENG  = 2'd2
    } rd_tag_t;

    localparam logic [3:0] MAX_WAIT = 4'(pMAX_WAIT);

    rd_tag_t    rd_tag_q, rd_tag_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    logic cfg_rd;
    logic cfg_wr;
    logic force_cfg;
    logic cfg_win;
    logic eng_win;

    // Grant decision: engine normally wins a read conflict; a starved config
    // read wins once its loss count saturates. Writes need an idle engine.
    always_comb begin
        cfg_rd    = cfg_req & ~cfg_we;
        cfg_wr    = cfg_req & cfg_we;
        force_cfg = (wait_cnt_q == MAX_WAIT);
        eng_win   = eng_req & ~(cfg_rd & force_cfg);
        if (cfg_rd) begin
            cfg_win = ~eng_req | force_cfg;
        end else begin
            cfg_win = cfg_wr & ~eng_busy & ~eng_req;
        end
        // Grants are suppressed while reset is held so every output reads 0.
        cfg_gnt = cfg_win & ~axis_rst;
        eng_gnt = eng_win & ~axis_rst;
    end

    // Next-state for the loss counter and the read-return tag.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!cfg_req || cfg_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (cfg_rd && eng_gnt && (wait_cnt_q != MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        rd_tag_d = TAG_NONE;
        if (cfg_gnt && !cfg_we) begin
            rd_tag_d = TAG_CFG;
        end else if (eng_gnt) begin
            rd_tag_d = TAG_ENG;
        end
    end

    // State registers; the tag is cleared by reset so an in-flight read is dropped.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            wait_cnt_q <= 4'd0;
            rd_tag_q   <= TAG_NONE;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_tag_q   <= rd_tag_d;
        end
    end

    // BRAM port drive follows the granted requester; idle drives all zeros.
    always_comb begin
        tap_EN = cfg_gnt | eng_gnt;
        tap_WE = 4'h0;
        tap_Di = '0;
        tap_A  = '0;
        if (cfg_gnt) begin
            tap_A = cfg_addr;
            if (cfg_we) begin
                tap_WE = 4'hF;
                tap_Di = cfg_wdata;
            end
        end else if (eng_gnt) begin
            tap_A = eng_addr;
        end
    end

    // Read return: the BRAM output is steered to whichever port the tag names.
    always_comb begin
        cfg_rvalid = (rd_tag_q == TAG_CFG) & ~axis_rst;
        eng_rvalid = (rd_tag_q == TAG_ENG) & ~axis_rst;
        cfg_rdata  = cfg_rvalid ? tap_Do : '0;
        eng_rdata  = eng_rvalid ? tap_Do : '0;
    end

`ifdef FIR_TAP_ARB_STATS_EN
    logic        eng_busy_q;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Stall counter restarts on each new frame and saturates at all ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (eng_busy && !eng_busy_q) begin
            stall_cnt_d = 16'd0;
        end else if (cfg_req && !cfg_gnt && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter and busy-edge history registers.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            eng_busy_q  <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            eng_busy_q  <= eng_busy;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cfg_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fir_tap_ram_arbiter.sv
// Directed bench for fir_tap_ram_arbiter with a behavioural tap BRAM
// (1-cycle registered read). Inputs change 1 ns after the rising edge and
// outputs are sampled 2 ns after it.
module tb_fir_tap_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          axis_clk;
    logic          axis_rst;
    logic          cfg_req;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          cfg_gnt;
    logic          cfg_rvalid;
    logic [DW-1:0] cfg_rdata;
    logic          eng_req;
    logic [AW-1:0] eng_addr;
    logic          eng_gnt;
    logic          eng_rvalid;
    logic [DW-1:0] eng_rdata;
    logic          eng_busy;
    logic [3:0]    tap_WE;
    logic          tap_EN;
    logic [DW-1:0] tap_Di;
    logic [AW-1:0] tap_A;
    logic [DW-1:0] tap_Do;
`ifdef FIR_TAP_ARB_STATS_EN
    logic [15:0]   cfg_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    int coef [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    fir_tap_ram_arbiter #(
        .pADDR_WIDTH(AW),
        .pDATA_WIDTH(DW),
        .pMAX_WAIT  (4)
    ) dut (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .cfg_req   (cfg_req),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_gnt   (cfg_gnt),
        .cfg_rvalid(cfg_rvalid),
        .cfg_rdata (cfg_rdata),
        .eng_req   (eng_req),
        .eng_addr  (eng_addr),
        .eng_gnt   (eng_gnt),
        .eng_rvalid(eng_rvalid),
        .eng_rdata (eng_rdata),
        .eng_busy  (eng_busy),
        .tap_WE    (tap_WE),
        .tap_EN    (tap_EN),
        .tap_Di    (tap_Di),
        .tap_A     (tap_A),
        .tap_Do    (tap_Do)
`ifdef FIR_TAP_ARB_STATS_EN
        ,
        .cfg_stall_cnt(cfg_stall_cnt)
`endif
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    // Behavioural tap BRAM: word-addressed, registered read.
    logic [DW-1:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        tap_Do = '0;
    end
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
            tap_Do <= mem[tap_A[5:2]];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_cfg_gnt"},    32'(cfg_gnt),    32'd0);
        check_val({tag, "_eng_gnt"},    32'(eng_gnt),    32'd0);
        check_val({tag, "_cfg_rvalid"}, 32'(cfg_rvalid), 32'd0);
        check_val({tag, "_eng_rvalid"}, 32'(eng_rvalid), 32'd0);
        check_val({tag, "_cfg_rdata"},  cfg_rdata,       32'd0);
        check_val({tag, "_eng_rdata"},  eng_rdata,       32'd0);
        check_val({tag, "_tap_EN"},     32'(tap_EN),     32'd0);
        check_val({tag, "_tap_WE"},     32'(tap_WE),     32'd0);
        check_val({tag, "_tap_Di"},     tap_Di,          32'd0);
        check_val({tag, "_tap_A"},      32'(tap_A),      32'd0);
    endtask

    initial begin
        int  prev_eng;
        bit  prev_cfg;
        bit  exp_eng;
        bit  exp_cfg;

        axis_rst  = 1'b1;
        cfg_req   = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        eng_req   = 1'b0;
        eng_addr  = '0;
        eng_busy  = 1'b0;

        // Reset state
        tick();
        tick();
        check_all_zero("rst");
        axis_rst = 1'b0;
        tick();

        // Load the 11 coefficients with the engine idle
        for (int i = 0; i < 11; i++) begin
            cfg_req   = 1'b1;
            cfg_we    = 1'b1;
            cfg_addr  = AW'(i * 4);
            cfg_wdata = 32'(coef[i]);
            #1;
            check_val($sformatf("wr%0d_gnt", i), 32'(cfg_gnt), 32'd1);
            check_val($sformatf("wr%0d_we", i),  32'(tap_WE),  32'hF);
            check_val($sformatf("wr%0d_a", i),   32'(tap_A),   32'(i * 4));
            check_val($sformatf("wr%0d_di", i),  tap_Di,       32'(coef[i]));
            $display("txn cfg_wr addr=%0h data=%0d", i * 4, coef[i]);
            tick();
        end
        cfg_req = 1'b0;
        cfg_we  = 1'b0;

        // Readback of 0x14
        cfg_req  = 1'b1;
        cfg_addr = 12'h014;
        #1;
        check_val("rd14_gnt", 32'(cfg_gnt), 32'd1);
        tick();
        cfg_req = 1'b0;
        #1;
        check_val("rd14_rvalid", 32'(cfg_rvalid), 32'd1);
        check_val("rd14_rdata",  cfg_rdata,       32'd63);
        check_val("rd14_eng_rv", 32'(eng_rvalid), 32'd0);
        $display("txn cfg_rd addr=14 data=%0d", $signed(cfg_rdata));
        tick();

        // Write blocked while a frame is in flight
        eng_busy = 1'b1;
        tick();
        cfg_req   = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 12'h008;
        cfg_wdata = 32'd5;
        for (int k = 0; k < 20; k++) begin
            #1;
            check_val($sformatf("blk%0d_gnt", k), 32'(cfg_gnt), 32'd0);
            check_val($sformatf("blk%0d_en", k),  32'(tap_EN),  32'd0);
            tick();
        end
`ifdef FIR_TAP_ARB_STATS_EN
        check_val("stall_cnt_20", 32'(cfg_stall_cnt), 32'd20);
`endif
        eng_busy = 1'b0;
        #1;
        check_val("unblk_gnt", 32'(cfg_gnt), 32'd1);
        check_val("unblk_we",  32'(tap_WE),  32'hF);
        check_val("unblk_a",   32'(tap_A),   32'h8);
        check_val("unblk_di",  tap_Di,       32'd5);
        $display("txn cfg_wr addr=8 data=5 after busy drop");
        tick();
        cfg_we = 1'b0;
        #1;
        check_val("rd08_gnt", 32'(cfg_gnt), 32'd1);
        tick();
        cfg_req = 1'b0;
        #1;
        check_val("rd08_rvalid", 32'(cfg_rvalid), 32'd1);
        check_val("rd08_rdata",  cfg_rdata,       32'd5);
        $display("txn cfg_rd addr=8 data=%0d", cfg_rdata);
`ifdef FIR_TAP_ARB_STATS_EN
        check_val("stall_cnt_hold", 32'(cfg_stall_cnt), 32'd20);
        eng_busy = 1'b1;
        tick();
        check_val("stall_cnt_clr", 32'(cfg_stall_cnt), 32'd0);
        eng_busy = 1'b0;
`endif
        tick();
        // Restore coefficient 2 so later expectations use the original table.
        mem[2] = 32'(coef[2]);

        // Engine streaming while a config read waits for its forced grant
        prev_eng = -1;
        prev_cfg = 1'b0;
        eng_req  = 1'b1;
        cfg_req  = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = 12'h010;
        for (int k = 0; k < 6; k++) begin
            eng_addr = AW'((k % 11) * 4);
            if (k == 5) cfg_req = 1'b0;
            #1;
            if (prev_eng >= 0) begin
                check_val($sformatf("st%0d_eng_rv", k), 32'(eng_rvalid), 32'd1);
                check_val($sformatf("st%0d_eng_rd", k), eng_rdata, 32'(coef[prev_eng]));
            end else begin
                check_val($sformatf("st%0d_eng_rv0", k), 32'(eng_rvalid), 32'd0);
            end
            if (prev_cfg) begin
                check_val($sformatf("st%0d_cfg_rv", k), 32'(cfg_rvalid), 32'd1);
                check_val($sformatf("st%0d_cfg_rd", k), cfg_rdata, 32'd56);
            end
            exp_cfg = (k == 4);
            exp_eng = !exp_cfg;
            check_val($sformatf("st%0d_eng_gnt", k), 32'(eng_gnt), 32'(exp_eng));
            check_val($sformatf("st%0d_cfg_gnt", k), 32'(cfg_gnt), 32'(exp_cfg));
            $display("txn stream k=%0d eng_gnt=%0d cfg_gnt=%0d", k, eng_gnt, cfg_gnt);
            prev_eng = exp_eng ? (k % 11) : -1;
            prev_cfg = exp_cfg;
            tick();
        end
        eng_req = 1'b0;
        #1;
        check_val("st_end_eng_rv", 32'(eng_rvalid), 32'd1);
        check_val("st_end_eng_rd", eng_rdata, 32'(coef[5]));
        tick();

        // Alternating single-cycle engine and config reads
        prev_eng = -1;
        prev_cfg = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                eng_req  = 1'b1;
                eng_addr = AW'(k * 4);
                cfg_req  = 1'b0;
            end else begin
                eng_req  = 1'b0;
                cfg_req  = 1'b1;
                cfg_we   = 1'b0;
                cfg_addr = AW'(k * 4);
            end
            #1;
            check_val($sformatf("alt%0d_both", k), 32'(eng_rvalid & cfg_rvalid), 32'd0);
            if (prev_eng >= 0) begin
                check_val($sformatf("alt%0d_eng_rv", k), 32'(eng_rvalid), 32'd1);
                check_val($sformatf("alt%0d_eng_rd", k), eng_rdata, 32'(coef[prev_eng]));
                check_val($sformatf("alt%0d_cfg_rd0", k), cfg_rdata, 32'd0);
            end
            if (prev_cfg) begin
                check_val($sformatf("alt%0d_cfg_rv", k), 32'(cfg_rvalid), 32'd1);
                check_val($sformatf("alt%0d_cfg_rd", k), cfg_rdata, 32'(coef[k - 1]));
                check_val($sformatf("alt%0d_eng_rd0", k), eng_rdata, 32'd0);
            end
            check_val($sformatf("alt%0d_gnt", k), 32'({eng_gnt, cfg_gnt}),
                      (k % 2 == 0) ? 32'd2 : 32'd1);
            $display("txn alt k=%0d eng_gnt=%0d cfg_gnt=%0d", k, eng_gnt, cfg_gnt);
            prev_eng = (k % 2 == 0) ? k : -1;
            prev_cfg = (k % 2 == 1);
            tick();
        end
        eng_req = 1'b0;
        cfg_req = 1'b0;
        #1;
        check_val("alt_end_cfg_rv", 32'(cfg_rvalid), 32'd1);
        check_val("alt_end_cfg_rd", cfg_rdata, 32'(coef[9]));
        check_val("alt_end_eng_rv", 32'(eng_rvalid), 32'd0);
        tick();

        // Reset right after an engine read grant drops the pending return
        eng_req  = 1'b1;
        eng_addr = 12'h014;
        #1;
        check_val("rstrd_gnt", 32'(eng_gnt), 32'd1);
        tick();
        axis_rst  = 1'b1;
        cfg_req   = 1'b1;
        cfg_we    = 1'b1;
        cfg_wdata = 32'hDEAD_BEEF;
        #1;
        check_all_zero("inrst");
        tick();
        check_all_zero("inrst2");
        eng_req  = 1'b0;
        cfg_req  = 1'b0;
        cfg_we   = 1'b0;
        axis_rst = 1'b0;
        #1;
        check_val("postrst_eng_rv", 32'(eng_rvalid), 32'd0);
        tick();
        check_val("postrst_eng_rv2", 32'(eng_rvalid), 32'd0);
        check_val("postrst_cfg_rv2", 32'(cfg_rvalid), 32'd0);
        $display("txn reset during pending engine read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
